// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and address-width helper for the
// multi-ported register file and its scoreboard.
package regfile_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } rf_state_e;

   function automatic int rf_aw(input int nregs);
      return (nregs <= 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer bits: set on issue, cleared on write, issue wins a tie.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int NWR   = 2,
   parameter int AW    = rf_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [AW-1:0]     set_addr,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   output logic [NREGS-1:0]  pending
);

   logic [NREGS-1:0] pend_d;
   logic [NREGS-1:0] pend_q;

   // NOTE: combinational blocks assign a default first and use '=' so no latch
   // is inferred; only the flop block below uses '<='.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NWR; i++) begin
         if (clr_en[i]) pend_d[clr_addr[i*AW +: AW]] = 1'b0;
      end
      // Applied after the clears so a same-cycle reissue keeps the new producer outstanding.
      if (set_en) pend_d[set_addr] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pend_q <= '0;
      else        pend_q <= pend_d;
   end

   assign pending = pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with x0 hardwired to zero, write-to-read bypass,
// pending scoreboard and a post-reset sweep that zeroes one entry per cycle.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   localparam int AW   = rf_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_valid,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   output logic                ready
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   rf_state_e        state_d;
   rf_state_e        state_q;
   logic [AW-1:0]    cnt_d;
   logic [AW-1:0]    cnt_q;
   logic [XLEN-1:0]  mem_q [NREGS];
   logic [NREGS-1:0] pending;
   logic [NWR-1:0]   wr_act;
   logic             iss_act;
   logic             clearing;

   assign ready    = (state_q == ST_READY);
   assign clearing = (state_q == ST_CLEAR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clearing) begin
         if (cnt_q == LAST_IDX) state_d = ST_READY;
         else                   cnt_d   = cnt_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      wr_act = '0;
      for (int i = 0; i < NWR; i++) begin
         wr_act[i] = ready && wr_en[i] && (wr_addr[i*AW +: AW] != '0);
      end
      iss_act = ready && iss_en && (iss_addr != '0);
   end

   // NOTE: the storage array has no reset term; the CLEAR sweep zeroes it
   // after reset, one entry per cycle.
   always_ff @(posedge clk) begin
      if (clearing) mem_q[cnt_q] <= '0;
      for (int i = 0; i < NWR; i++) begin
         if (wr_act[i]) mem_q[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
      end
   end

   always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      for (int p = 0; p < NRD; p++) begin
         if (ready && rd_en[p]) begin
            if (rd_addr[p*AW +: AW] == '0) begin
               rd_valid[p] = 1'b1;
            end else begin
               rd_data[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
               rd_valid[p]             = !pending[rd_addr[p*AW +: AW]];
               // Ascending port order lets write port 1 override port 0 here too.
               for (int i = 0; i < NWR; i++) begin
                  if (wr_act[i] && (wr_addr[i*AW +: AW] == rd_addr[p*AW +: AW])) begin
                     rd_data[p*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                     rd_valid[p]             = 1'b1;
                  end
               end
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR),
      .AW    (AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (iss_act),
      .set_addr (iss_addr),
      .clr_en   (wr_act),
      .clr_addr (wr_addr),
      .pending  (pending)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic compared against an array-based behavioural model.
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_valid;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                ready;

   int n_checks = 0;
   int n_errors = 0;

   // Model: architectural contents, outstanding producers, edges since reset release.
   logic [XLEN-1:0] ref_mem  [NREGS];
   bit              ref_pend [NREGS];
   int              ref_cycles;

   regfile_mp #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .NRD   (NRD),
      .NWR   (NWR)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_ready();
      return (rst_n === 1'b1) && (ref_cycles >= NREGS - 1);
   endfunction

   task automatic ref_reset();
      for (int i = 0; i < NREGS; i++) begin
         ref_mem[i]  = '0;
         ref_pend[i] = 1'b0;
      end
      ref_cycles = 0;
   endtask

   // Expected outputs for the inputs currently applied.
   task automatic check_outputs();
      logic [AW-1:0]   a;
      logic [XLEN-1:0] exp_d;
      bit              exp_v;
      check("ready", ready, ref_ready());
      for (int p = 0; p < NRD; p++) begin
         a     = rd_addr[p*AW +: AW];
         exp_d = '0;
         exp_v = 1'b0;
         if (ref_ready() && rd_en[p]) begin
            if (a == 0) begin
               exp_v = 1'b1;
            end else begin
               exp_d = ref_mem[a];
               exp_v = !ref_pend[a];
               // A read sees the latest value written to it this cycle.
               for (int i = 0; i < NWR; i++) begin
                  if (wr_en[i] && wr_addr[i*AW +: AW] == a) begin
                     exp_d = wr_data[i*XLEN +: XLEN];
                     exp_v = 1'b1;
                  end
               end
            end
         end
         check($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], exp_d);
         check($sformatf("rd_valid[%0d]", p), rd_valid[p], exp_v);
      end
   endtask

   task automatic model_edge();
      logic [AW-1:0] a;
      if (rst_n !== 1'b1) return;
      if (ref_ready()) begin
         for (int i = 0; i < NWR; i++) begin
            a = wr_addr[i*AW +: AW];
            if (wr_en[i] && a != 0) begin
               ref_mem[a]  = wr_data[i*XLEN +: XLEN];
               ref_pend[a] = 1'b0;
            end
         end
         if (iss_en && iss_addr != 0) ref_pend[iss_addr] = 1'b1;
      end
      if (ref_cycles < 1000) ref_cycles++;
   endtask

   task automatic settle();
      #1;
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic idle_inputs();
      rd_en    = '0;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic set_rd(input int p, input bit en, input int a);
      rd_en[p]            = en;
      rd_addr[p*AW +: AW] = a[AW-1:0];
   endtask

   task automatic set_wr(input int i, input bit en, input int a, input logic [XLEN-1:0] d);
      wr_en[i]                = en;
      wr_addr[i*AW +: AW]     = a[AW-1:0];
      wr_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic set_iss(input bit en, input int a);
      iss_en   = en;
      iss_addr = a[AW-1:0];
   endtask

   function automatic int rand_addr();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1))
                                         : int'($urandom_range(0, 7));
   endfunction

   task automatic assert_reset();
      rst_n = 1'b0;
      ref_reset();
      settle();
      check("ready_drops_async", ready, 1'b0);
   endtask

   // Counts edges from reset release until ready, with random reads throughout.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
         idle_inputs();
         for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 1), rand_addr());
         set_wr(0, 1'b1, rand_addr(), $urandom());
         set_iss(1'b1, rand_addr());
         tick();
         n++;
      end
      check(tag, n, NREGS - 1);
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      ref_reset();
      repeat (2) @(posedge clk);
      #1;
      settle();
      rst_n = 1'b1;
      wait_ready("ready_latency");

      // Freshly cleared file reads zero everywhere.
      for (int k = 0; k < 8; k++) begin
         idle_inputs();
         set_rd(0, 1'b1, $urandom_range(0, NREGS - 1));
         set_rd(1, 1'b1, $urandom_range(0, NREGS - 1));
         tick();
      end

      // Same-cycle bypass then storage for x5.
      idle_inputs();
      set_wr(0, 1'b1, 5, 32'hDEADBEEF);
      set_rd(0, 1'b1, 5);
      settle();
      check("x5_bypass_data", rd_data[31:0], 32'hDEADBEEF);
      check("x5_bypass_valid", rd_valid[0], 1'b1);
      advance();
      idle_inputs();
      set_rd(0, 1'b1, 5);
      settle();
      check("x5_stored_data", rd_data[31:0], 32'hDEADBEEF);
      advance();

      // Both write ports to x7: port 1 wins.
      idle_inputs();
      set_wr(0, 1'b1, 7, 32'h11);
      set_wr(1, 1'b1, 7, 32'h22);
      set_rd(1, 1'b1, 7);
      settle();
      check("x7_bypass_data", rd_data[63:32], 32'h22);
      advance();
      idle_inputs();
      set_rd(0, 1'b1, 7);
      settle();
      check("x7_stored_data", rd_data[31:0], 32'h22);
      advance();

      // Issue x9, read pending, write clears.
      idle_inputs();
      set_iss(1'b1, 9);
      tick();
      idle_inputs();
      set_rd(0, 1'b1, 9);
      settle();
      check("x9_pending_valid", rd_valid[0], 1'b0);
      advance();
      idle_inputs();
      set_wr(0, 1'b1, 9, 32'h5);
      set_rd(0, 1'b1, 9);
      settle();
      check("x9_bypass_valid", rd_valid[0], 1'b1);
      check("x9_bypass_data", rd_data[31:0], 32'h5);
      advance();
      idle_inputs();
      set_rd(0, 1'b1, 9);
      settle();
      check("x9_cleared_valid", rd_valid[0], 1'b1);
      check("x9_stored_data", rd_data[31:0], 32'h5);
      advance();

      // Issue and write x3 in one cycle: data stored, still pending.
      idle_inputs();
      set_iss(1'b1, 3);
      set_wr(1, 1'b1, 3, 32'h33);
      tick();
      idle_inputs();
      set_rd(0, 1'b1, 3);
      settle();
      check("x3_still_pending", rd_valid[0], 1'b0);
      check("x3_stored_data", rd_data[31:0], 32'h33);
      advance();

      // Writes to x0 are dropped.
      idle_inputs();
      set_wr(0, 1'b1, 0, 32'hFF);
      set_rd(1, 1'b1, 0);
      settle();
      check("x0_write_bypass_data", rd_data[63:32], 32'h0);
      check("x0_write_bypass_valid", rd_valid[1], 1'b1);
      advance();
      idle_inputs();
      set_rd(0, 1'b1, 0);
      settle();
      check("x0_read_data", rd_data[31:0], 32'h0);
      advance();

      // Reset mid-operation with x9 pending.
      idle_inputs();
      set_iss(1'b1, 9);
      tick();
      idle_inputs();
      assert_reset();
      advance();
      rst_n = 1'b1;
      wait_ready("ready_latency_after_op_reset");
      idle_inputs();
      set_rd(0, 1'b1, 9);
      set_rd(1, 1'b1, 7);
      settle();
      check("x9_pending_reset", rd_valid[0], 1'b1);
      check("x7_recleared", rd_data[63:32], 32'h0);
      advance();

      // Reset again ten cycles into the clear sweep.
      idle_inputs();
      assert_reset();
      advance();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      idle_inputs();
      assert_reset();
      advance();
      rst_n = 1'b1;
      wait_ready("ready_latency_after_clear_reset");

      // Randomized traffic against the model.
      for (int k = 0; k < 2000; k++) begin
         idle_inputs();
         for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, 3) != 0, rand_addr());
         for (int i = 0; i < NWR; i++) set_wr(i, $urandom_range(0, 1), rand_addr(), $urandom());
         set_iss($urandom_range(0, 2) == 0, rand_addr());
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
